// File: rtl/m6800_bus_ctrl_if.sv
// M6800 peripheral bus signal bundle used by m6800_bus_ctrl.
// The slave modport is the controller's view; the master modport is the
// CPU / bench side. With M6800_EXT_E_EN defined the bundle also carries
// the external E input and its select.
interface m6800_bus_ctrl_if;

  logic VPA_n;
  logic AS_CPU_n;
  logic CPUSPACE;
  logic E;
  logic E_OE;
  logic VMA_n;
  logic M6800_DTACK_n;
  logic E_RISE_STB;
  logic E_FALL_STB;
  logic CYCLE_ACTIVE;
`ifdef M6800_EXT_E_EN
  logic EXT_E_SEL;
  logic E_IN;
`endif

`ifdef M6800_EXT_E_EN
  modport master (
    output VPA_n, AS_CPU_n, CPUSPACE, EXT_E_SEL, E_IN,
    input  E, E_OE, VMA_n, M6800_DTACK_n, E_RISE_STB, E_FALL_STB, CYCLE_ACTIVE
  );

  modport slave (
    input  VPA_n, AS_CPU_n, CPUSPACE, EXT_E_SEL, E_IN,
    output E, E_OE, VMA_n, M6800_DTACK_n, E_RISE_STB, E_FALL_STB, CYCLE_ACTIVE
  );
`else
  modport master (
    output VPA_n, AS_CPU_n, CPUSPACE,
    input  E, E_OE, VMA_n, M6800_DTACK_n, E_RISE_STB, E_FALL_STB, CYCLE_ACTIVE
  );

  modport slave (
    input  VPA_n, AS_CPU_n, CPUSPACE,
    output E, E_OE, VMA_n, M6800_DTACK_n, E_RISE_STB, E_FALL_STB, CYCLE_ACTIVE
  );
`endif

endinterface

// File: rtl/m6800_bus_ctrl.sv
// m6800_bus_ctrl: generates the 6800 E clock from C7M and runs the
// VPA_n -> VMA_n -> M6800_DTACK_n handshake for 6800-style peripheral cycles.
// Everything is clocked on the falling edge of C7M; RESET_n is synchronous,
// active-low.
//
// Optional feature: define M6800_EXT_E_EN to add EXT_E_SEL / E_IN, which let
// the phase counter lock onto an externally supplied E clock (E_OE then
// drops so the E pin is not driven). Without it E_OE is tied high.
//
// FSM transitions look at the phase value held during the clock that ends
// at the deciding edge: VMA_n drops on the edge closing phase VMA_PHASE and
// DTACK drops on the edge closing phase E_PERIOD-1, so VMA_n has been low
// across the whole E-high window before DTACK appears.
module m6800_bus_ctrl #(
  parameter int E_PERIOD  = 10,
  parameter int E_LOW     = 6,
  parameter int VMA_PHASE = 3
) (
  input  logic              C7M,
  input  logic              RESET_n,
  m6800_bus_ctrl_if.slave   bus
);

  localparam int PW     = (E_PERIOD > 1) ? $clog2(E_PERIOD) : 1;
  localparam int E_HIGH = E_PERIOD - E_LOW;

  localparam logic [PW-1:0] PH_LAST   = PW'(E_PERIOD - 1);
  localparam logic [PW-1:0] PH_ELOW   = PW'(E_LOW);
  localparam logic [PW-1:0] PH_VMA    = PW'(VMA_PHASE);
  localparam logic [PW-1:0] PH_RESET  = PW'(E_LOW - 1);
  localparam logic [PW-1:0] PH_RESYNC = PW'((E_LOW + 2) % E_PERIOD);
  localparam logic [PW-1:0] HI_FULL   = PW'(E_HIGH);
  localparam logic [PW-1:0] HI_LAST   = PW'(E_HIGH - 1);

  // Reject timings where E or the VMA window cannot be formed
  generate
    if (E_PERIOD < 4 || E_LOW < 1 || E_LOW > E_PERIOD - 3 ||
        VMA_PHASE < 0 || VMA_PHASE >= E_LOW) begin : g_bad_params
      $error("m6800_bus_ctrl: need E_PERIOD>=4, 1<=E_LOW<=E_PERIOD-3, VMA_PHASE<E_LOW");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    VMA  = 2'd2,
    ACK  = 2'd3
  } state_t;

  logic [PW-1:0] phase;
  logic [PW-1:0] phase_next;
  logic          e_q;
  logic          e_rise_q;
  logic          e_fall_q;

  state_t        state;
  state_t        state_next;
  logic          vma_n_q;
  logic          dtack_n_q;
  logic [PW-1:0] hi_cnt;
  logic          hi_done;

`ifdef M6800_EXT_E_EN
  logic          e_sync1;
  logic          e_sync2;
  logic          e_sync3;
  logic          e_oe_q;
  logic          ext_rise;

  // Two-flop synchroniser for the external E plus one flop for edge detect
  always_ff @(negedge C7M) begin
    if (!RESET_n) begin
      e_sync1 <= 1'b0;
      e_sync2 <= 1'b0;
      e_sync3 <= 1'b0;
      e_oe_q  <= 1'b1;
    end else begin
      e_sync1 <= bus.E_IN;
      e_sync2 <= e_sync1;
      e_sync3 <= e_sync2;
      e_oe_q  <= !bus.EXT_E_SEL;
    end
  end

  assign ext_rise = bus.EXT_E_SEL && e_sync2 && !e_sync3;
  assign bus.E_OE = e_oe_q;
`else
  assign bus.E_OE = 1'b1;
`endif

  // Next phase: wrap at E_PERIOD-1, or jump to the lock point on an external E rise
  always_comb begin
    phase_next = (phase == PH_LAST) ? '0 : phase + PW'(1);
`ifdef M6800_EXT_E_EN
    if (ext_rise) begin
      phase_next = PH_RESYNC;
    end
`endif
  end

  // Phase counter, registered E and its edge strobes
  always_ff @(negedge C7M) begin
    if (!RESET_n) begin
      phase    <= PH_RESET;
      e_q      <= 1'b0;
      e_rise_q <= 1'b0;
      e_fall_q <= 1'b0;
    end else begin
      phase    <= phase_next;
      e_q      <= (phase_next >= PH_ELOW);
      e_rise_q <= (phase_next >= PH_ELOW) && !e_q;
      e_fall_q <= (phase_next <  PH_ELOW) &&  e_q;
    end
  end

  // Count E-high clocks seen while VMA_n is low; a phase jump from an
  // external E resync cannot then shorten the window DTACK depends on
  always_ff @(negedge C7M) begin
    if (!RESET_n) begin
      hi_cnt <= '0;
    end else if (state != VMA) begin
      hi_cnt <= '0;
    end else if (e_q && hi_cnt != HI_FULL) begin
      hi_cnt <= hi_cnt + PW'(1);
    end
  end

  assign hi_done = e_q && (hi_cnt >= HI_LAST);

  // Next-state logic; a negated address strobe beats every other transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (!bus.AS_CPU_n && !bus.VPA_n && !bus.CPUSPACE) begin
          state_next = SYNC;
        end
      end
      SYNC: begin
        if (bus.VPA_n) begin
          state_next = IDLE;
        end else if (phase == PH_VMA) begin
          state_next = VMA;
        end
      end
      VMA: begin
        if (bus.VPA_n) begin
          state_next = IDLE;
        end else if (phase == PH_LAST && hi_done) begin
          state_next = ACK;
        end
      end
      ACK: begin
        state_next = ACK;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (bus.AS_CPU_n) begin
      state_next = IDLE;
    end
  end

  // State register with VMA_n / DTACK registered from the state being entered
  always_ff @(negedge C7M) begin
    if (!RESET_n) begin
      state     <= IDLE;
      vma_n_q   <= 1'b1;
      dtack_n_q <= 1'b1;
    end else begin
      state     <= state_next;
      vma_n_q   <= !((state_next == VMA) || (state_next == ACK));
      dtack_n_q <= (state_next != ACK);
    end
  end

  assign bus.E             = e_q;
  assign bus.E_RISE_STB    = e_rise_q;
  assign bus.E_FALL_STB    = e_fall_q;
  assign bus.VMA_n         = vma_n_q;
  assign bus.M6800_DTACK_n = dtack_n_q;
  assign bus.CYCLE_ACTIVE  = (state != IDLE);

endmodule

// File: tb/tb_m6800_bus_ctrl.sv
// Testbench for m6800_bus_ctrl: directed bus cycles against a behavioural
// model of the E clock and VPA/VMA/DTACK handshake, compared every clock,
// plus hand-computed latency and timing expectations.
module tb_m6800_bus_ctrl;

  localparam int E_PERIOD  = 10;
  localparam int E_LOW     = 6;
  localparam int VMA_PHASE = 3;

  logic C7M;
  logic RESET_n;

  m6800_bus_ctrl_if bus ();

  m6800_bus_ctrl #(
    .E_PERIOD  (E_PERIOD),
    .E_LOW     (E_LOW),
    .VMA_PHASE (VMA_PHASE)
  ) dut (
    .C7M     (C7M),
    .RESET_n (RESET_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: phase as an integer, E and strobes from it, and three flags
  // describing how far the current bus cycle has progressed
  int m_phase = 0;
  bit m_e     = 1'b0;
  bit m_rise  = 1'b0;
  bit m_fall  = 1'b0;
  bit m_busy  = 1'b0;
  bit m_vma   = 1'b0;
  bit m_ack   = 1'b0;
  bit model_valid = 1'b0;

  initial C7M = 1'b1;
  always #5 C7M = ~C7M;

  task automatic checkOutput(input string name, input logic actual, input logic expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %b, expected %b at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkCount(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic as_n, input logic vpa_n, input logic cpuspace);
    bus.AS_CPU_n = as_n;
    bus.VPA_n    = vpa_n;
    bus.CPUSPACE = cpuspace;
  endtask

  // Wait (bounded) until the model says the current phase is p
  task automatic waitPhase(input int p);
    int n;
    n = 0;
    while (m_phase != p && n < 3 * E_PERIOD) begin
      @(posedge C7M);
      n++;
    end
    if (n >= 3 * E_PERIOD) checkCount("wait_phase_timeout", n, 0);
  endtask

  // Behavioural model: E is high for phases E_LOW..E_PERIOD-1; a cycle
  // arms on a valid VPA request, asserts VMA at the end of phase VMA_PHASE,
  // acknowledges at the end of the last phase, and is dropped by AS_CPU_n=1
  // (anywhere) or VPA_n=1 (before acknowledge)
  always @(negedge C7M) begin
    int np;
    if (!RESET_n) begin
      m_phase = E_LOW - 1;
      m_e     = 1'b0;
      m_rise  = 1'b0;
      m_fall  = 1'b0;
      m_busy  = 1'b0;
      m_vma   = 1'b0;
      m_ack   = 1'b0;
      model_valid = 1'b1;
    end else begin
      np = (m_phase + 1) % E_PERIOD;
      if (bus.AS_CPU_n) begin
        m_busy = 1'b0; m_vma = 1'b0; m_ack = 1'b0;
      end else if (m_ack) begin
        m_ack = 1'b1;
      end else if (m_vma) begin
        if (bus.VPA_n) begin
          m_busy = 1'b0; m_vma = 1'b0;
        end else if (m_phase == E_PERIOD - 1) begin
          m_ack = 1'b1;
        end
      end else if (m_busy) begin
        if (bus.VPA_n) m_busy = 1'b0;
        else if (m_phase == VMA_PHASE) m_vma = 1'b1;
      end else if (!bus.VPA_n && !bus.CPUSPACE) begin
        m_busy = 1'b1;
      end
      m_rise  = (np == E_LOW);
      m_fall  = (np == 0);
      m_e     = (np >= E_LOW);
      m_phase = np;
    end
  end

  // Compare every DUT output with the model half a clock after each update
  always @(posedge C7M) begin
    if (model_valid) begin
      checkOutput("E", bus.E, m_e);
      checkOutput("E_RISE_STB", bus.E_RISE_STB, m_rise);
      checkOutput("E_FALL_STB", bus.E_FALL_STB, m_fall);
      checkOutput("VMA_n", bus.VMA_n, !m_vma);
      checkOutput("DTACK_n", bus.M6800_DTACK_n, !m_ack);
      checkOutput("CYCLE_ACTIVE", bus.CYCLE_ACTIVE, m_busy);
      checkOutput("E_OE", bus.E_OE, 1'b1);
    end
  end

  // Global time limit in case a wait somehow never returns
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    int n;
    int hi;
    int falls;
    bit seen;

    RESET_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
`ifdef M6800_EXT_E_EN
    bus.EXT_E_SEL = 1'b0;
    bus.E_IN      = 1'b0;
`endif
    repeat (3) @(posedge C7M);

    // Reset state
    checkOutput("rst_E", bus.E, 1'b0);
    checkOutput("rst_VMA_n", bus.VMA_n, 1'b1);
    checkOutput("rst_DTACK_n", bus.M6800_DTACK_n, 1'b1);
    checkOutput("rst_ACTIVE", bus.CYCLE_ACTIVE, 1'b0);
    checkOutput("rst_E_OE", bus.E_OE, 1'b1);
    checkOutput("rst_RISE", bus.E_RISE_STB, 1'b0);
    checkOutput("rst_FALL", bus.E_FALL_STB, 1'b0);

    // E rises one clock after release
    RESET_n = 1'b1;
    @(posedge C7M);
    checkOutput("first_rise_E", bus.E, 1'b1);
    checkOutput("first_rise_stb", bus.E_RISE_STB, 1'b1);

    // Free-running E: 10-clock period, 4 high, one fall per period
    n = 0; hi = 1; falls = 0;
    do begin
      @(posedge C7M);
      n++;
      if (bus.E && !bus.E_RISE_STB) hi++;
      if (bus.E_FALL_STB) falls++;
    end while (!bus.E_RISE_STB && n < 3 * E_PERIOD);
    checkCount("e_period", n, 10);
    checkCount("e_high", hi, 4);
    checkCount("e_falls_per_period", falls, 1);

    // Normal VPA cycle requested during phase 7
    waitPhase(7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin @(posedge C7M); n++; end while (bus.VMA_n && n < 40);
    checkCount("vma_latency_p7", n, 7);
    do begin @(posedge C7M); n++; end while (bus.M6800_DTACK_n && n < 40);
    checkCount("dtack_latency_p7", n, 13);
    repeat (3) @(posedge C7M);
    checkOutput("ack_hold_vma", bus.VMA_n, 1'b0);
    checkOutput("ack_hold_dtack", bus.M6800_DTACK_n, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge C7M);
    checkOutput("end_vma", bus.VMA_n, 1'b1);
    checkOutput("end_dtack", bus.M6800_DTACK_n, 1'b1);
    checkOutput("end_active", bus.CYCLE_ACTIVE, 1'b0);

    // CPU-space (autovector) cycle never leaves idle
    applyStimulus(1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    repeat (30) begin
      @(posedge C7M);
      if (!bus.VMA_n || !bus.M6800_DTACK_n || bus.CYCLE_ACTIVE) seen = 1'b1;
    end
    checkOutput("cpuspace_quiet", seen, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge C7M);

    // Request on phase 3 boundary waits a whole period for the next phase 3
    waitPhase(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin @(posedge C7M); n++; end while (bus.VMA_n && n < 40);
    checkCount("vma_latency_p3", n, 11);
    do begin @(posedge C7M); n++; end while (bus.M6800_DTACK_n && n < 40);
    checkCount("dtack_latency_p3", n, 17);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge C7M);

    // AS_CPU_n rises during VMA at phase 7: abort without DTACK
    waitPhase(7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin @(posedge C7M); n++; end while (bus.VMA_n && n < 40);
    checkCount("abort_as_vma_seen", n, 7);
    waitPhase(7);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(posedge C7M);
    checkOutput("abort_as_active", bus.CYCLE_ACTIVE, 1'b0);
    checkOutput("abort_as_vma", bus.VMA_n, 1'b1);
    seen = !bus.M6800_DTACK_n;
    repeat (15) begin
      @(posedge C7M);
      if (!bus.M6800_DTACK_n) seen = 1'b1;
    end
    checkOutput("abort_as_no_dtack", seen, 1'b0);

    // VPA_n negated while synchronising
    waitPhase(7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge C7M);
    checkOutput("sync_active", bus.CYCLE_ACTIVE, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(posedge C7M);
    checkOutput("abort_vpa_sync_active", bus.CYCLE_ACTIVE, 1'b0);
    checkOutput("abort_vpa_sync_vma", bus.VMA_n, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge C7M);

    // VPA_n negated while VMA is asserted
    waitPhase(0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin @(posedge C7M); n++; end while (bus.VMA_n && n < 40);
    checkCount("vpa_abort_vma_latency", n, 4);
    applyStimulus(1'b0, 1'b1, 1'b0);
    @(posedge C7M);
    checkOutput("abort_vpa_vma_vma", bus.VMA_n, 1'b1);
    checkOutput("abort_vpa_vma_dtack", bus.M6800_DTACK_n, 1'b1);
    checkOutput("abort_vpa_vma_active", bus.CYCLE_ACTIVE, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge C7M);

    // One-clock reset during ACK
    waitPhase(7);
    applyStimulus(1'b0, 1'b0, 1'b0);
    n = 0;
    do begin @(posedge C7M); n++; end while (bus.M6800_DTACK_n && n < 40);
    checkCount("rst_ack_dtack_latency", n, 13);
    RESET_n = 1'b0;
    @(posedge C7M);
    checkOutput("mid_rst_E", bus.E, 1'b0);
    checkOutput("mid_rst_VMA_n", bus.VMA_n, 1'b1);
    checkOutput("mid_rst_DTACK_n", bus.M6800_DTACK_n, 1'b1);
    checkOutput("mid_rst_ACTIVE", bus.CYCLE_ACTIVE, 1'b0);
    checkOutput("mid_rst_RISE", bus.E_RISE_STB, 1'b0);
    RESET_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    @(posedge C7M);
    checkOutput("post_rst_E", bus.E, 1'b1);
    checkOutput("post_rst_RISE", bus.E_RISE_STB, 1'b1);

    repeat (12) @(posedge C7M);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
